pad_dir_ctrl: RTL
=================

// Module: pad_dir_ctrl
// PURPOSE
// - Parametrised direction controller for N_CH parallel SPI data pad banks, placed between the async-FIFO SPI channels and the pad ring.
// - Per channel, it decides when the chip drives the pads and when the host drives them. It inserts turnaround dead cycles and synchronises the host OE request.
// - It registers outgoing and incoming data and flags drive conflicts. Each channel is configured as BIDIR, OUT_ONLY or IN_ONLY.
// PARAMETERS
// - N_CH         3        number of pad channels
// - SPI_WIDTH    32       data bits per channel
// - TA_CYCLES    2        dead cycles per direction change (0..15; 0 = no gap)
// - SYNC_STAGES  2        flops in host_oe_req synchroniser (>=2)
// - CH_MODE      6'b000001  2 bits per channel, ch0 in LSBs: 0=BIDIR, 1=OUT_ONLY, 2=IN_ONLY (3 treated as IN_ONLY)
// PORTS
// - clk_chip        in   1              chip clock
// - reset_n_chip    in   1              async active-low reset
// - chip_req        in   N_CH           core wants to drive channel (config_req)
// - host_oe_req     in   N_CH           host drives bus; asynchronous, from pad
// - core_dout       in   N_CH*SPI_WIDTH data to pads, ch i at [i*SPI_WIDTH +: SPI_WIDTH]
// - pad_do          out  N_CH*SPI_WIDTH registered pad output data
// - pad_oe          out  N_CH           pad output enable (flop output)
// - pad_ie          out  N_CH           pad input enable
// - pad_di          in   N_CH*SPI_WIDTH pad input data
// - core_din        out  N_CH*SPI_WIDTH registered pad input data
// - core_din_valid  out  N_CH           host driving and chip in HIZ
// - drive_grant     out  N_CH           chip owns bus (state DRIVE)
// - conflict        out  N_CH           sticky: host_oe seen while DRIVE
// - conflict_clr    in   N_CH           pulse clears conflict
// BEHAVIOUR
// - Reset (async) behaviour:
//   - All outputs 0; pad_ie = 0 for OUT_ONLY, 1 otherwise.
//   - Synchroniser, counters and flags cleared; FSM = HIZ. pad_oe drops immediately on reset, even mid-drive.
// - host_sync = host_oe_req after SYNC_STAGES flops; all FSM decisions use host_sync only.
// - FSM per channel: HIZ, TA_OUT, DRIVE, TA_IN. pad_oe flop = 1 exactly when state==DRIVE.
// - BIDIR transitions:
//   - HIZ -> TA_OUT when chip_req && !host_sync.
//   - TA_OUT: counter loaded TA_CYCLES-1, decrements. Go to DRIVE at count 0. Abort to HIZ if !chip_req || host_sync.
//   - TA_CYCLES=0: HIZ -> DRIVE directly.
//   - DRIVE -> TA_IN when !chip_req || host_sync.
//   - TA_IN counts TA_CYCLES, then HIZ. chip_req is ignored in TA_IN. TA_CYCLES=0: DRIVE -> HIZ.
// - Latency (BIDIR): chip_req high at edge t with host_sync low gives pad_oe high from edge t+1+TA_CYCLES. Deassert at t gives pad_oe low at t+1.
// - OUT_ONLY: HIZ -> DRIVE on first edge after reset release; stays there regardless of chip_req/host_sync. pad_ie=0.
// - IN_ONLY: stays in HIZ; pad_oe=0, drive_grant=0.
// - Data paths:
//   - pad_do <= core_dout every cycle (1-cycle latency, independent of state).
//   - core_din <= pad_di every cycle.
//   - core_din_valid <= (state==HIZ && host_sync).
// - conflict set when state==DRIVE && host_sync (BIDIR and OUT_ONLY); cleared by conflict_clr. Set wins over simultaneous clear.
// - Simultaneous rise of chip_req and host_sync in HIZ: host wins, stay HIZ.
// - Counter width is 4 bits; no wrap possible within range.
// STRUCTURE
// - Package pad_dir_pkg: state enum (HIZ, TA_OUT, DRIVE, TA_IN), MODE_BIDIR/MODE_OUT/MODE_IN constants, TA counter width.
// - Sub-module pad_dir_ch: one channel (synchroniser, FSM, counter, conflict flag, data flops).
// - Top instantiates it N_CH times via generate, passing CH_MODE[2*i +: 2].
// TESTING
// - Reset and OUT_ONLY: release reset with defaults.
//   - Ch0 pad_oe=1 and drive_grant=1 one edge after release; ch1/2 pad_oe=0, pad_ie=1.
// - BIDIR drive-up: ch1 chip_req=1, host_oe_req=0.
//   - pad_oe[1] rises exactly 3 edges later (TA_CYCLES=2).
//   - pad_do[63:32] = 32'hA5A5_0001 one edge after core_dout is set.
// - Host preemption: ch1 in DRIVE, host_oe_req[1]=1.
//   - pad_oe[1] low 3 edges later (2 sync + 1); conflict[1]=1 held until conflict_clr.
//   - core_din_valid[1]=1 after TA_IN completes (2 more cycles).
// - Abort in turnaround: chip_req[2] drops during TA_OUT -> HIZ next edge; pad_oe[2] never rises.
// - Clear vs set: conflict_clr[0] in the same cycle as a new conflict on ch0 -> conflict[0] stays 1.
// - Mid-drive reset: assert reset_n_chip=0 while ch1 in DRIVE.
//   - pad_oe goes 0 without a clock edge.
//   - After release, ch1 returns to DRIVE after TA_CYCLES+1 edges if chip_req stays high.

Source files
------------

// File: rtl/pad_dir_pkg.sv
// Shared types and constants for the pad direction controller.
package pad_dir_pkg;

    // Per-channel direction state.
    typedef enum logic [1:0] {
        HIZ    = 2'd0,
        TA_OUT = 2'd1,
        DRIVE  = 2'd2,
        TA_IN  = 2'd3
    } pad_state_e;

    // Two-bit channel mode codes; code 3 behaves like MODE_IN.
    localparam logic [1:0] MODE_BIDIR = 2'd0;
    localparam logic [1:0] MODE_OUT   = 2'd1;
    localparam logic [1:0] MODE_IN    = 2'd2;

    // Turnaround counter width, enough for 0..15 dead cycles.
    localparam int TA_CNT_W = 4;

endpackage

// File: rtl/pad_dir_ch.sv
// One pad channel: host OE synchroniser, direction FSM with turnaround
// counter, sticky conflict flag and the registered data paths.
//
// state  | meaning
// HIZ    | pads released, host may drive
// TA_OUT | dead cycles before the chip drives
// DRIVE  | chip owns the bus
// TA_IN  | dead cycles after the chip releases
module pad_dir_ch
    import pad_dir_pkg::*;
#(
    parameter int         SPI_WIDTH   = 32,
    parameter int         TA_CYCLES   = 2,
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] MODE        = MODE_BIDIR
) (
    input  logic                 clk_chip,
    input  logic                 reset_n_chip,
    input  logic                 i_chip_req,
    input  logic                 i_host_oe_req,
    input  logic                 i_conflict_clr,
    input  logic [SPI_WIDTH-1:0] i_core_dout,
    input  logic [SPI_WIDTH-1:0] i_pad_di,
    output logic [SPI_WIDTH-1:0] o_pad_do,
    output logic                 o_pad_oe,
    output logic                 o_pad_ie,
    output logic [SPI_WIDTH-1:0] o_core_din,
    output logic                 o_core_din_valid,
    output logic                 o_drive_grant,
    output logic                 o_conflict
);

    localparam logic IS_BIDIR = (MODE == MODE_BIDIR);
    localparam logic IS_OUT   = (MODE == MODE_OUT);
    // Counter runs from TA_LOAD down to 0, so a turnaround lasts TA_CYCLES cycles.
    localparam logic [TA_CNT_W-1:0] TA_LOAD =
        (TA_CYCLES == 0) ? '0 : TA_CNT_W'(TA_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_host_sync;
    pad_state_e             r_state;
    logic [TA_CNT_W-1:0]    r_cnt;
    logic                   r_oe;
    logic                   r_grant;
    logic                   r_din_valid;
    logic                   r_conflict;
    logic                   r_ie;
    logic [SPI_WIDTH-1:0]   r_do;
    logic [SPI_WIDTH-1:0]   r_din;

    assign w_host_sync = r_sync[SYNC_STAGES-1];

    // Bring the asynchronous host OE request into the chip clock domain.
    always_ff @(posedge clk_chip or negedge reset_n_chip) begin
        if (!reset_n_chip) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_host_oe_req};
        end
    end

    // Direction FSM with its registered outputs; pad_oe follows DRIVE one edge later.
    always_ff @(posedge clk_chip or negedge reset_n_chip) begin
        if (!reset_n_chip) begin
            r_state     <= HIZ;
            r_cnt       <= '0;
            r_oe        <= 1'b0;
            r_grant     <= 1'b0;
            r_din_valid <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            // OUT_ONLY enables on the first edge after reset along with its DRIVE entry.
            r_oe        <= (r_state == DRIVE) || IS_OUT;
            r_grant     <= (r_state == DRIVE) || IS_OUT;
            r_din_valid <= (r_state == HIZ) && w_host_sync;

            // Setting beats a simultaneous clear so a fresh conflict is never lost.
            if ((r_state == DRIVE) && w_host_sync) begin
                r_conflict <= 1'b1;
            end else if (i_conflict_clr) begin
                r_conflict <= 1'b0;
            end

            if (IS_OUT) begin
                r_state <= DRIVE;
            end else if (!IS_BIDIR) begin
                r_state <= HIZ;
            end else begin
                case (r_state)
                    HIZ: begin
                        if (i_chip_req && !w_host_sync) begin
                            if (TA_CYCLES == 0) begin
                                r_state <= DRIVE;
                            end else begin
                                r_state <= TA_OUT;
                                r_cnt   <= TA_LOAD;
                            end
                        end
                    end
                    TA_OUT: begin
                        if (!i_chip_req || w_host_sync) begin
                            r_state <= HIZ;
                        end else if (r_cnt == '0) begin
                            r_state <= DRIVE;
                        end else begin
                            r_cnt <= r_cnt - TA_CNT_W'(1);
                        end
                    end
                    DRIVE: begin
                        if (!i_chip_req || w_host_sync) begin
                            if (TA_CYCLES == 0) begin
                                r_state <= HIZ;
                            end else begin
                                r_state <= TA_IN;
                                r_cnt   <= TA_LOAD;
                            end
                        end
                    end
                    TA_IN: begin
                        if (r_cnt == '0) begin
                            r_state <= HIZ;
                        end else begin
                            r_cnt <= r_cnt - TA_CNT_W'(1);
                        end
                    end
                    default: r_state <= HIZ;
                endcase
            end
        end
    end

    // Data flops run every cycle regardless of direction; input enable is fixed by mode.
    always_ff @(posedge clk_chip or negedge reset_n_chip) begin
        if (!reset_n_chip) begin
            r_do  <= '0;
            r_din <= '0;
            r_ie  <= !IS_OUT;
        end else begin
            r_do  <= i_core_dout;
            r_din <= i_pad_di;
            r_ie  <= !IS_OUT;
        end
    end

    assign o_pad_do         = r_do;
    assign o_pad_oe         = r_oe;
    assign o_pad_ie         = r_ie;
    assign o_core_din       = r_din;
    assign o_core_din_valid = r_din_valid;
    assign o_drive_grant    = r_grant;
    assign o_conflict       = r_conflict;

endmodule

// File: rtl/pad_dir_ctrl.sv
// Direction controller for N_CH SPI data pad banks; one pad_dir_ch per bank.
module pad_dir_ctrl
    import pad_dir_pkg::*;
#(
    parameter int                N_CH        = 3,
    parameter int                SPI_WIDTH   = 32,
    parameter int                TA_CYCLES   = 2,
    parameter int                SYNC_STAGES = 2,
    parameter logic [2*N_CH-1:0] CH_MODE     = 6'b000001
) (
    input  logic                      clk_chip,
    input  logic                      reset_n_chip,
    input  logic [N_CH-1:0]           chip_req,
    input  logic [N_CH-1:0]           host_oe_req,
    input  logic [N_CH*SPI_WIDTH-1:0] core_dout,
    output logic [N_CH*SPI_WIDTH-1:0] pad_do,
    output logic [N_CH-1:0]           pad_oe,
    output logic [N_CH-1:0]           pad_ie,
    input  logic [N_CH*SPI_WIDTH-1:0] pad_di,
    output logic [N_CH*SPI_WIDTH-1:0] core_din,
    output logic [N_CH-1:0]           core_din_valid,
    output logic [N_CH-1:0]           drive_grant,
    output logic [N_CH-1:0]           conflict,
    input  logic [N_CH-1:0]           conflict_clr
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pad_dir_ch #(
            .SPI_WIDTH   (SPI_WIDTH),
            .TA_CYCLES   (TA_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .MODE        (CH_MODE[2*gi +: 2])
        ) u_ch (
            .clk_chip         (clk_chip),
            .reset_n_chip     (reset_n_chip),
            .i_chip_req       (chip_req[gi]),
            .i_host_oe_req    (host_oe_req[gi]),
            .i_conflict_clr   (conflict_clr[gi]),
            .i_core_dout      (core_dout[gi*SPI_WIDTH +: SPI_WIDTH]),
            .i_pad_di         (pad_di[gi*SPI_WIDTH +: SPI_WIDTH]),
            .o_pad_do         (pad_do[gi*SPI_WIDTH +: SPI_WIDTH]),
            .o_pad_oe         (pad_oe[gi]),
            .o_pad_ie         (pad_ie[gi]),
            .o_core_din       (core_din[gi*SPI_WIDTH +: SPI_WIDTH]),
            .o_core_din_valid (core_din_valid[gi]),
            .o_drive_grant    (drive_grant[gi]),
            .o_conflict       (conflict[gi])
        );
    end

endmodule
